piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter DATA_W, default 8: frame width in bits, legal range 1..32.
REQ-002 Parameter DIV, default 100: clk cycles per half bit period, legal range 1..2^20.
REQ-003 Parameter MSB_FIRST, default 0: 0 = bit 0 shifted first, 1 = bit DATA_W-1 shifted first.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 CR  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 datain  input  DATA_W  parallel word, captured only on an accepted start.
REQ-007 start  input  1  request to begin a frame, level-sampled.
REQ-008 sdt  input  1  run enable; 0 freezes all non-reset state.
REQ-009 dataout  output  1  serial data bit.
REQ-010 sclk  output  1  serial bit clock.
REQ-011 cs  output  1  frame select, high while bits are on the line.
REQ-012 busy  output  1  high from start acceptance until done.
REQ-013 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and GUARD.
REQ-015 In IDLE, start=1 with sdt=1 SHALL capture datain into the shift register, clear the divider, and enter SHIFT next cycle.
REQ-016 start SHALL be ignored while busy=1 or sdt=0.
REQ-017 Divider SHALL count 0..DIV-1 while sdt=1 and emit tick on count DIV-1, then wrap to 0.
REQ-018 In SHIFT, cs SHALL be 1 and sclk SHALL be 0 for the first DIV cycles of each bit and 1 for the second DIV cycles.
REQ-019 dataout SHALL present the current bit for the full 2*DIV cycles of that bit; bits change only on the sclk high-to-low transition.
REQ-020 Bit order SHALL follow MSB_FIRST.
REQ-021 After the high-half tick of the last bit, the FSM SHALL enter GUARD with cs=0, sclk=0 and dataout=0 for DIV cycles.
REQ-022 On the GUARD tick, the FSM SHALL return to IDLE, with done=1 and busy=0 in that first IDLE cycle.
REQ-023 start in the same cycle as done SHALL be accepted, giving back-to-back frames.
REQ-024 cs SHALL stay high for exactly DATA_W*2*DIV cycles per frame when sdt is held at 1.
REQ-025 sdt=0 SHALL hold divider, FSM, shift register and all outputs unchanged; when sdt returns to 1, operation resumes from the held count.
REQ-026 In IDLE, cs, sclk, dataout and busy SHALL be 0.
REQ-027 datain changes after capture SHALL NOT affect the frame in progress.

Reset
REQ-028 CR=1 SHALL force IDLE and clear divider, shift register, bit counter, dataout, sclk, cs, busy and done to 0 on the next clk edge.
REQ-029 CR SHALL override sdt and start.
REQ-030 CR asserted mid-frame SHALL abort the frame without a done pulse.

Structure
REQ-031 Package piso_pkg SHALL hold the FSM state type and the default parameter constants.
REQ-032 The divider SHALL be a sub-module clk_div_tick with parameter DIV and ports clk, CR, en, clr, tick.
REQ-033 Bit counter and divider widths SHALL be derived from DATA_W and DIV via $clog2.

Verification (DATA_W=8, DIV=4 unless noted)
REQ-034 datain=8'hA5, MSB_FIRST=0, start pulse at cycle 0 -> dataout 1,0,1,0,0,1,0,1, each for 8 cycles; cs high cycles 1..64; GUARD cycles 65..68; done=1 at cycle 69 only.
REQ-035 Same stimulus with MSB_FIRST=1 -> dataout 1,0,1,0,0,1,0,1 (palindrome), then datain=8'h01 -> 0 for seven bits and 1 for the last bit.
REQ-036 start held high continuously with datain changing each cycle -> back-to-back frames, each carrying the word present on its acceptance cycle; second cs rise at cycle 70.
REQ-037 sdt=0 for 10 cycles at cycle 20 -> all outputs frozen; done shifts to cycle 79.
REQ-038 CR=1 at cycle 30 -> all outputs 0 at cycle 31, no done pulse; a new start at cycle 35 produces a normal frame.
REQ-039 DATA_W=1, DIV=1, datain=1 -> cs high for 2 cycles, sclk 0 then 1, done 2 cycles after cs falls.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in / serial-out serializer.
package piso_pkg;

    // Frame sequencing: wait for start, shift bits out, hold the line quiet.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DIV       = 100;
    localparam bit DEF_MSB_FIRST = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Free-running 0..DIV-1 divider; tick marks the last count of each period.
module clk_div_tick
    import piso_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic CR,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;

    // Tick only while enabled so a frozen divider never advances the FSM.
    assign tick = en && (count_reg == LAST);

    // Count while enabled; clr restarts the period so a frame starts aligned.
    always_ff @(posedge clk) begin
        if (CR) begin
            count_reg <= '0;
        end else if (en) begin
            if (clr || count_reg == LAST) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out frame transmitter with sclk/cs framing and a
// one-period guard gap after each frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DIV       = DEF_DIV,
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic              clk,
    input  logic              CR,
    input  logic [DATA_W-1:0] datain,
    input  logic              start,
    input  logic              sdt,
    output logic              dataout,
    output logic              sclk,
    output logic              cs,
    output logic              busy,
    output logic              done
);

    localparam int            BW       = cnt_width(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [BW-1:0]     bit_cnt_reg;
    logic              dataout_reg;
    logic              sclk_reg;
    logic              cs_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              tick;
    logic              accept;
    logic              datain_head;
    logic              next_head;

    // A start is only honoured from IDLE while running (busy is 0 in IDLE).
    assign accept = sdt && start && (state_reg == IDLE);

    // Bit order selects which end of the word leaves first and the shift direction.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next  = shift_reg << 1;
            assign datain_head = datain[DATA_W-1];
            assign next_head   = shift_next[DATA_W-1];
        end else begin : g_lsb_first
            assign shift_next  = shift_reg >> 1;
            assign datain_head = datain[0];
            assign next_head   = shift_next[0];
        end
    endgenerate

    clk_div_tick #(
        .DIV (DIV)
    ) u_div (
        .clk  (clk),
        .CR   (CR),
        .en   (sdt),
        .clr  (accept),
        .tick (tick)
    );

    // Frame FSM with registered line outputs; sdt low freezes everything.
    always_ff @(posedge clk) begin
        if (CR) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            dataout_reg <= 1'b0;
            sclk_reg    <= 1'b0;
            cs_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else if (sdt) begin
            case (state_reg)
                IDLE: begin
                    done_reg    <= 1'b0;
                    busy_reg    <= 1'b0;
                    cs_reg      <= 1'b0;
                    sclk_reg    <= 1'b0;
                    dataout_reg <= 1'b0;
                    if (start) begin
                        shift_reg   <= datain;
                        bit_cnt_reg <= '0;
                        dataout_reg <= datain_head;
                        cs_reg      <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_reg) begin
                            // End of the low half: raise sclk, data stays put.
                            sclk_reg <= 1'b1;
                        end else if (bit_cnt_reg == LAST_BIT) begin
                            state_reg   <= GUARD;
                            cs_reg      <= 1'b0;
                            sclk_reg    <= 1'b0;
                            dataout_reg <= 1'b0;
                        end else begin
                            // Falling sclk is the only point where data moves.
                            sclk_reg    <= 1'b0;
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_next;
                            dataout_reg <= next_head;
                        end
                    end
                end
                GUARD: begin
                    if (tick) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign dataout = dataout_reg;
    assign sclk    = sclk_reg;
    assign cs      = cs_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule
